// File: rtl/alu_operand_entry.sv
// alu_operand_entry: debounced DE2 key/switch entry of two 32-bit operands and an ALU opcode,
// issued to the ALU through a valid/ready handshake.
module alu_operand_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [3:0]  key_n,
  input  logic [17:0] sw,
  output logic [31:0] port_a,
  output logic [31:0] port_b,
  output logic [3:0]  aluop,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [2:0]  stage,
  output logic [3:0]  press
);
  typedef enum logic [2:0] {
    A_LO  = 3'd0,
    A_HI  = 3'd1,
    B_LO  = 3'd2,
    B_HI  = 3'd3,
    OP    = 3'd4,
    ISSUE = 3'd5
  } state_t;
  logic [3:0]            s1_q, s2_q, stable_q, stable_d, press_q, press_d;
  logic [3:0][CNT_W-1:0] cnt_q, cnt_d;
  state_t                st_q, st_d;
  logic [31:0]           a_q, a_d, b_q, b_d;
  logic [3:0]            op_q, op_d;
  logic                  valid_q;
  logic                  enter, back, clear, xfer;
  logic                  unused_sw;
  assign unused_sw = sw[17];
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < 4; i++)
      if (s2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) stable_d[i] = s2_q[i];
        else cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    press_d = stable_q & ~stable_d;
  end
  assign clear = press_q[2];
  assign back  = press_q[1];
  assign enter = press_q[0];
  assign xfer  = (st_q == ISSUE) && op_ready;
  // CLEAR outranks a simultaneous transfer; the transfer still happens since op_valid was up.
  always_comb begin
    st_d = st_q;
    a_d  = a_q;
    b_d  = b_q;
    op_d = op_q;
    if (clear) begin
      st_d = A_LO;
      a_d  = '0;
      b_d  = '0;
      op_d = '0;
    end else if (xfer) begin
      st_d = A_LO;
    end else if (back) begin
      case (st_q)
        B_HI, OP: st_d = B_LO;
        ISSUE:    st_d = OP;
        default:  st_d = A_LO;
      endcase
    end else if (enter) begin
      case (st_q)
        A_LO: begin
          a_d  = sw[16] ? {{16{sw[15]}}, sw[15:0]} : {a_q[31:16], sw[15:0]};
          st_d = sw[16] ? B_LO : A_HI;
        end
        A_HI: begin
          a_d  = {sw[15:0], a_q[15:0]};
          st_d = B_LO;
        end
        B_LO: begin
          b_d  = sw[16] ? {{16{sw[15]}}, sw[15:0]} : {b_q[31:16], sw[15:0]};
          st_d = sw[16] ? OP : B_HI;
        end
        B_HI: begin
          b_d  = {sw[15:0], b_q[15:0]};
          st_d = OP;
        end
        OP: begin
          op_d = sw[3:0];
          st_d = ISSUE;
        end
        ISSUE:   st_d = ISSUE;
        default: st_d = A_LO;
      endcase
    end else if (st_q > ISSUE) begin
      st_d = A_LO;
    end
  end
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      s1_q     <= '1;
      s2_q     <= '1;
      stable_q <= '1;
      cnt_q    <= '0;
      press_q  <= '0;
      st_q     <= A_LO;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      valid_q  <= 1'b0;
    end else begin
      s1_q     <= key_n;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
      st_q     <= st_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      valid_q  <= (st_d == ISSUE);
    end
  end
  assign port_a   = a_q;
  assign port_b   = b_q;
  assign aluop    = op_q;
  assign op_valid = valid_q;
  assign stage    = st_q;
  assign press    = press_q;
endmodule

// File: tb/tb_alu_operand_entry.sv
// tb_alu_operand_entry: directed plus randomized key/switch entry checked against a behavioural model.
module tb_alu_operand_entry;
  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic [3:0]  key_n = 4'hF;
  logic [17:0] sw = '0;
  logic        op_ready = 1'b0;
  logic [31:0] port_a, port_b;
  logic [3:0]  aluop, press;
  logic        op_valid;
  logic [2:0]  stage;
  int          total = 0, bad = 0;
  logic [31:0] ea = '0, eb = '0;
  logic [3:0]  eop = '0;
  int          est = 0;
  alu_operand_entry #(.DEBOUNCE_CYCLES(4), .CNT_W(4)) dut (
    .CLK(CLK), .nRST(nRST), .key_n(key_n), .sw(sw),
    .port_a(port_a), .port_b(port_b), .aluop(aluop),
    .op_valid(op_valid), .op_ready(op_ready), .stage(stage), .press(press)
  );
  always #5 CLK = ~CLK;
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic chk_all(input string tag);
    chk({tag, ".stage"}, 32'(stage), 32'(est));
    chk({tag, ".port_a"}, port_a, ea);
    chk({tag, ".port_b"}, port_b, eb);
    chk({tag, ".aluop"}, 32'(aluop), 32'(eop));
    chk({tag, ".op_valid"}, 32'(op_valid), 32'(est == 5));
  endtask
  // Key effect on the entry model, using the switch value present at the press.
  function automatic void model(input logic [3:0] m, input logic [17:0] s);
    logic [15:0] lo;
    lo = s[15:0];
    if (m[2]) begin
      ea = 0; eb = 0; eop = 0; est = 0;
    end else if (m[1]) begin
      if (est == 1 || est == 2) est = 0;
      else if (est == 3 || est == 4) est = 2;
      else if (est == 5) est = 4;
    end else if (m[0]) begin
      case (est)
        0: begin
          if (s[16]) begin ea = 32'($signed(lo)); est = 2; end
          else begin ea = (ea & 32'hFFFF0000) + 32'(lo); est = 1; end
        end
        1: begin ea = (ea & 32'h0000FFFF) + (32'(lo) << 16); est = 2; end
        2: begin
          if (s[16]) begin eb = 32'($signed(lo)); est = 4; end
          else begin eb = (eb & 32'hFFFF0000) + 32'(lo); est = 3; end
        end
        3: begin eb = (eb & 32'h0000FFFF) + (32'(lo) << 16); est = 4; end
        4: begin eop = s[3:0]; est = 5; end
        default: ;
      endcase
    end
  endfunction
  task automatic do_press(input logic [3:0] m, input int hold);
    int n, lat;
    n = 0;
    lat = -1;
    key_n = ~m;
    for (int t = 1; t <= hold + 8; t++) begin
      if (t == hold + 1) key_n = 4'hF;
      tick;
      if (press != 0) begin
        n++;
        if (lat < 0) lat = t;
        chk("pulse_mask", 32'(press), 32'(m));
      end
    end
    chk("press_latency", lat, 6);
    chk("press_count", n, 1);
    model(m, sw);
  endtask
  initial begin
    int n;
    repeat (3) tick;
    chk_all("reset");
    chk("reset.press", 32'(press), 0);
    nRST = 1'b1;
    tick;
    key_n[0] = 1'b0;
    repeat (3) tick;
    key_n[0] = 1'b1;
    n = 0;
    repeat (10) begin
      tick;
      if (press != 0) n++;
    end
    chk("glitch_pulses", n, 0);
    chk_all("glitch");
    sw = 18'h0_1234;
    do_press(4'b0001, 10);
    chk_all("a_lo");
    sw = 18'h0_ABCD;
    do_press(4'b0001, 10);
    chk("a_full", port_a, 32'hABCD1234);
    sw = 18'h1_8001;
    do_press(4'b0001, 10);
    chk("b_sext", port_b, 32'hFFFF8001);
    chk("b_skip_hi", 32'(stage), 4);
    sw = 18'h0_0003;
    do_press(4'b0001, 10);
    chk("aluop", 32'(aluop), 3);
    chk_all("issue");
    for (int i = 0; i < 20; i++) begin
      sw = 18'($urandom);
      tick;
      chk("hold.valid", 32'(op_valid), 1);
      chk("hold.a", port_a, 32'hABCD1234);
      chk("hold.b", port_b, 32'hFFFF8001);
      chk("hold.op", 32'(aluop), 3);
    end
    op_ready = 1'b1;
    tick;
    op_ready = 1'b0;
    est = 0;
    chk("xfer.valid", 32'(op_valid), 0);
    chk("xfer.a_kept", port_a, 32'hABCD1234);
    chk_all("xfer");
    sw = 18'h1_0005;
    do_press(4'b0001, 10);
    sw = 18'h1_0006;
    do_press(4'b0001, 10);
    chk_all("to_op");
    do_press(4'b0010, 10);
    chk_all("back_op");
    do_press(4'b0010, 10);
    chk_all("back_blo");
    do_press(4'b0010, 10);
    chk_all("back_alo");
    for (int i = 0; i < 3; i++) begin
      sw = 18'($urandom) | 18'h1_0000;
      do_press(4'b0001, 10);
    end
    chk_all("issue2");
    do_press(4'b0110, 10);
    chk_all("clear_back");
    for (int i = 0; i < 30; i++) begin
      int r;
      r = $urandom_range(0, 9);
      sw = 18'($urandom);
      if (est == 5 && $urandom_range(0, 1) == 1) begin
        op_ready = 1'b1;
        tick;
        op_ready = 1'b0;
        est = 0;
        chk_all("rnd_xfer");
      end
      do_press(r < 6 ? 4'b0001 : r < 8 ? 4'b0010 : r < 9 ? 4'b0100 : 4'b1000, 10);
      chk_all("rnd");
    end
    nRST = 1'b0;
    repeat (2) tick;
    ea = 0; eb = 0; eop = 0; est = 0;
    chk_all("mid_reset");
    sw = 18'h0_4321;
    key_n[0] = 1'b0;
    tick;
    nRST = 1'b1;
    n = 0;
    repeat (12) begin
      tick;
      if (press != 0) n++;
    end
    chk("held_reset_pulses", n, 1);
    key_n = 4'hF;
    repeat (8) tick;
    model(4'b0001, sw);
    chk_all("held_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_operand_entry.md
Name: alu_operand_entry

Overview:
- Input-side companion to the ALU board display path.
- Takes raw DE2 pushbuttons and switches, then synchronises and debounces the keys.
- Steps through a small entry state machine that assembles two 32-bit operands and a 4-bit ALU opcode.
- Issues the result to the ALU interface with a valid/ready handshake; a stage code drives status LEDs.

Parameters:
- DEBOUNCE_CYCLES, 500000: cycles a key must stay stable before a change is accepted (10 ms at 50 MHz).
- CNT_W, 20: debounce counter width; must hold DEBOUNCE_CYCLES-1.

Ports:
- CLK  input  1  system clock.
- nRST  input  1  synchronous active-low reset.
- key_n  input  4  raw pushbuttons, active-low (0 = pressed), asynchronous.
- sw  input  18  raw slide switches, used level-only when sampled on a press.
- port_a  output  32  assembled operand A.
- port_b  output  32  assembled operand B.
- aluop  output  4  assembled opcode.
- op_valid  output  1  operand set ready for ALU.
- op_ready  input  1  ALU consumer accepts.
- stage  output  3  current FSM state encoding.
- press  output  4  one-cycle debounced press pulses, for LEDs/debug.

Behaviour:
- One clock, CLK. Reset is synchronous and active-low on nRST, sampled on the CLK rising edge. The reset values are:
  - port_a = 0, port_b = 0, aluop = 0.
  - op_valid = 0, press = 0.
  - stage = A_LO (0).
  - Synchroniser and stable-key registers = 1 (released); debounce counters = 0.
- Synchroniser: each key_n bit passes through 2 flops.
- Debounce, per key:
  - If the synced value equals the stable value, the counter is cleared.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 with the mismatch still present, stable takes the synced value and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles is rejected.
- press[i] is high for exactly 1 cycle on the stable 1->0 transition. A release produces no pulse. Holding a key produces one pulse only.
- Latency from a clean key_n fall to the press pulse is 2 + DEBOUNCE_CYCLES cycles.
- Key roles: KEY0 = ENTER, KEY1 = BACK, KEY2 = CLEAR, KEY3 = no FSM effect (press[3] is still reported).
- Same-cycle priority: CLEAR > BACK > ENTER.
- States (stage encoding): A_LO=0, A_HI=1, B_LO=2, B_HI=3, OP=4, ISSUE=5. Codes 6 and 7 are unreachable; if reached they go to A_LO.
- ENTER, with sw sampled in the press cycle:
  - A_LO: port_a[15:0] <= sw[15:0].
    - If sw[16]=1, port_a[31:16] <= {16{sw[15]}} and go to B_LO.
    - Else go to A_HI, leaving the upper half unchanged.
  - A_HI: port_a[31:16] <= sw[15:0], then go to B_LO.
  - B_LO / B_HI: same as A_LO / A_HI but on port_b; exits go to OP.
  - OP: aluop <= sw[3:0], then go to ISSUE.
  - ISSUE: ENTER is ignored.
- BACK transitions; no data register changes:
  - A_LO stays A_LO.
  - A_HI -> A_LO, B_LO -> A_LO, B_HI -> B_LO, OP -> B_LO, ISSUE -> OP.
- CLEAR, from any state: port_a, port_b and aluop go to 0, state goes to A_LO, and op_valid drops next cycle.
- Handshake:
  - op_valid = 1 exactly while the state is ISSUE (registered output).
  - port_a, port_b and aluop are held constant while op_valid = 1.
  - A transfer happens on a cycle with op_valid & op_ready. The next state is A_LO and the operands are retained for display.
  - op_ready is ignored outside ISSUE.
  - If op_ready and BACK occur together in ISSUE, the transfer counts and the next state is A_LO (transfer beats BACK).
  - If op_ready and CLEAR occur together in ISSUE, the transfer counts, then the registers zero and the next state is A_LO.
- Reset mid-debounce or mid-entry: everything returns to reset values. A key held through reset release produces one press after the debounce time, because stable was reset to released.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset with key_n=4'hF → all outputs 0 and stage=0. Hold key_n[0]=0 for 10 cycles → exactly one press[0] pulse, 6 cycles after the fall.
- key_n[0] glitch of 3 cycles → no press pulse and no state change.
- Full entry, one ENTER per step:
  - A_LO with sw=18'h0_1234 (sw[16]=0), then A_HI with sw=18'h0_ABCD → port_a=32'hABCD1234.
  - B_LO with sw=18'h1_8001 (sw[16]=1) → port_b=32'hFFFF8001 and the B_HI stage is skipped.
  - OP with sw[3:0]=4'h3 → aluop=3.
  - Result: stage=5, op_valid=1.
- Hold op_ready=0 for 20 cycles in ISSUE with sw toggling → op_valid stays 1 and the operands are unchanged. Then op_ready=1 for 1 cycle → op_valid=0 next cycle, stage=0, port_a still 32'hABCD1234.
- BACK sequence from OP → stage goes 4→2→0 with the registers unchanged. BACK in A_LO → stays 0.
- In ISSUE, CLEAR and BACK debounced presses land in the same cycle → stage=0 and port_a=port_b=aluop=0 (CLEAR wins).
